// File: rtl/fire9_expand1_ifm_feeder.sv
// Buffers 64 squeeze pixel vectors, then streams them one channel per cycle to expand1x1.
// Latency: ifm/expand_en lag the internal read counters by one registered cycle.
// Backpressure: none; samples arriving while full or after fill set a sticky overflow flag.
module fire9_expand1_ifm_feeder #(
  parameter int WOUT  = 8,
  parameter int CHIN  = 112,
  parameter int WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sq_sample,
  input  logic [0:CHIN-1][WIDTH-1:0]  sq_ofm,
  input  logic                        sq_finish,
  output logic                        expand_en,
  output logic [WIDTH-1:0]            ifm,
  output logic                        buf_release,
  output logic                        overflow
);

  localparam int NPIX = WOUT * WOUT;
  localparam int PW   = $clog2(NPIX + 1);
  localparam int RAW  = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int CW   = $clog2(CHIN + 1);
  localparam int CAW  = (CHIN > 1) ? $clog2(CHIN) : 1;

  localparam logic [PW-1:0] NPIX_C     = PW'(NPIX);
  localparam logic [PW-1:0] LAST_PIX_C = PW'(NPIX - 1);
  localparam logic [PW-1:0] PIX_ONE    = PW'(1);
  localparam logic [CW-1:0] CHIN_C     = CW'(CHIN);
  localparam logic [CW-1:0] CH_ONE     = CW'(1);

  typedef enum logic [1:0] {FILL, STREAM, DRAIN, DONE} state_t;

  state_t                     state_q, state_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              pix_q, pix_d;
  logic [CW-1:0]              ch_q, ch_d;
  logic                       expand_en_q, expand_en_d;
  logic [WIDTH-1:0]           ifm_q, ifm_d;
  logic                       buf_release_q, buf_release_d;
  logic                       released_q, released_d;
  logic                       overflow_q, overflow_d;
  logic                       wr_en;

  // One row per pixel, written CHIN words at a time; contents survive reset.
  logic [0:CHIN-1][WIDTH-1:0] mem [0:NPIX-1];

  // Row write port for captured squeeze vectors.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[RAW-1:0]] <= sq_ofm;
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= FILL;
      wr_ptr_q      <= '0;
      pix_q         <= '0;
      ch_q          <= '0;
      expand_en_q   <= 1'b0;
      ifm_q         <= '0;
      buf_release_q <= 1'b0;
      released_q    <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      pix_q         <= pix_d;
      ch_q          <= ch_d;
      expand_en_q   <= expand_en_d;
      ifm_q         <= ifm_d;
      buf_release_q <= buf_release_d;
      released_q    <= released_d;
      overflow_q    <= overflow_d;
    end
  end

  // Next-state, counters, buffer read and output staging.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    pix_d         = pix_q;
    ch_d          = ch_q;
    overflow_d    = overflow_q;
    wr_en         = 1'b0;
    ifm_d         = '0;
    expand_en_d   = (state_q == STREAM) || (state_q == DRAIN);
    buf_release_d = (state_q == DONE) && !released_q;
    released_d    = released_q || (state_q == DONE);

    case (state_q)
      FILL: begin
        if (sq_sample) begin
          if (wr_ptr_q != NPIX_C) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PIX_ONE;
          end else begin
            overflow_d = 1'b1;
          end
        end
        // Uses the post-write pointer so a final sample coincident with finish still counts.
        if (sq_finish && (wr_ptr_d == NPIX_C)) begin
          state_d = STREAM;
          pix_d   = '0;
          ch_d    = '0;
        end
      end
      STREAM: begin
        if (sq_sample) overflow_d = 1'b1;
        if (ch_q != CHIN_C) ifm_d = mem[pix_q[RAW-1:0]][ch_q[CAW-1:0]];
        if (ch_q == CHIN_C) begin
          ch_d  = '0;
          pix_d = pix_q + PIX_ONE;
          if (pix_q == LAST_PIX_C) state_d = DRAIN;
        end else begin
          ch_d = ch_q + CH_ONE;
        end
      end
      DRAIN: begin
        if (sq_sample) overflow_d = 1'b1;
        if (ch_q == CHIN_C) begin
          ch_d    = '0;
          state_d = DONE;
        end else begin
          ch_d = ch_q + CH_ONE;
        end
      end
      default: begin
        if (sq_sample) overflow_d = 1'b1;
      end
    endcase
  end

  assign expand_en   = expand_en_q;
  assign ifm         = ifm_q;
  assign buf_release = buf_release_q;
  assign overflow    = overflow_q;

endmodule
